// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by fetch_unit and fetch_fifo.
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH,
    DRAIN
  } fstate_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fentry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {addr, inst}.
// Synchronous flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_addr,
  input  logic [31:0]   push_inst,
  input  logic          pop,
  output logic [31:0]   head_addr,
  output logic [31:0]   head_inst,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  fentry_t       mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_addr = mem[rd].addr;
  assign head_inst = mem[rd].inst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      if (pop_ok)  rd <= rd + 1'b1;
      unique case (1'b1)
        push_ok && !pop_ok: count <= count + ONE;
        !push_ok && pop_ok: count <= count - ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr] <= '{addr: push_addr, inst: push_inst};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with in-order memory, prefetch buffer and redirect drain.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_o and aligns redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] Addr,
  output logic [31:0] Inst,
  output logic        InstValid,
  output logic        FetchBusy
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  fstate_t       state;
  fstate_t       state_n;
  logic [31:0]   pc;
  logic [31:0]   pc_n;
  logic [31:0]   tgt;
  logic [AW:0]   outst;
  logic [AW:0]   outst_n;
  logic [AW:0]   drop;
  logic [AW:0]   drop_n;
  logic [AW:0]   cnt;
  logic [31:0]   aq [DEPTH];
  logic [AW-1:0] aq_wr;
  logic [AW-1:0] aq_rd;
  logic          hs;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [31:0]   head_addr;
  logic [31:0]   head_inst;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt        = {PCTargetE[31:2], 2'b00};
  assign misalign_o = PCSrcE && (PCTargetE[1:0] != 2'b00);
`else
  assign tgt = PCTargetE;
`endif

  assign imem_addr      = pc;
  assign imem_req_valid = (state == FETCH) &&
                          ((cnt + outst) < (AW+1)'(DEPTH));
  assign hs             = imem_req_valid && imem_req_ready;

  // Responses to dropped requests never reach the buffer.
  assign push = imem_rsp_valid && (state == FETCH) &&
                (drop == '0) && !PCSrcE && (!full || pop);
  assign pop  = !StallF && !empty && !PCSrcE;

  assign Addr      = empty ? 32'h0 : head_addr;
  assign Inst      = empty ? NOP : head_inst;
  assign InstValid = !empty;
  assign FetchBusy = empty;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    outst_n = outst;
    drop_n  = drop;
    if (hs) pc_n = pc + 32'd4;
    unique case (1'b1)
      hs && !imem_rsp_valid: outst_n = outst + ONE;
      !hs && imem_rsp_valid: outst_n = outst - ONE;
      default: ;
    endcase
    if (state == DRAIN && imem_rsp_valid) drop_n = drop - ONE;
    // In FETCH every in-flight request, including this cycle's, goes stale.
    if (PCSrcE) begin
      pc_n = tgt;
      if (state == FETCH) drop_n = outst_n;
    end
    state_n = (drop_n != '0) ? DRAIN : FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      outst <= '0;
      drop  <= '0;
      aq_wr <= '0;
      aq_rd <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      outst <= outst_n;
      drop  <= drop_n;
      if (hs)             aq_wr <= aq_wr + 1'b1;
      if (imem_rsp_valid) aq_rd <= aq_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) aq[aq_wr] <= pc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (PCSrcE),
    .push      (push),
    .push_addr (aq[aq_rd]),
    .push_inst (imem_rsp_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_inst (head_inst),
    .full      (full),
    .empty     (empty),
    .count     (cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order variable-latency memory.
// Build with FETCH_MISALIGN_CHECK_EN to exercise misalign_o.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        InstValid;
  logic        FetchBusy;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  fetch_unit #(
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .StallF         (StallF),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .Addr           (Addr),
    .Inst           (Inst),
    .InstValid      (InstValid),
    .FetchBusy      (FetchBusy)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A00_0001;
  endfunction

  function automatic logic [31:0] tmodel(logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  fentry_t     exp_q[$];
  fentry_t     e;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] mpc = 32'h0;
  logic        s_rst = 1'b1;
  logic        s_hs = 1'b0;
  logic        s_rsp = 1'b0;
  logic        s_redir = 1'b0;
  logic [31:0] s_tgt = 32'h0;
  logic [31:0] s_addr = 32'h0;

  // Sample everything mid-cycle; scoreboard pops consumed heads.
  always @(negedge clk) begin
    s_rst   = rst;
    s_hs    = imem_req_valid && imem_req_ready;
    s_addr  = imem_addr;
    s_rsp   = imem_rsp_valid;
    s_redir = PCSrcE;
    s_tgt   = PCTargetE;
    if (!rst) begin
      if (imem_req_valid) check("imem_addr", imem_addr, mpc);
      if (InstValid && !StallF && !PCSrcE) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_addr", Addr, e.addr);
          check("sb_inst", Inst, e.inst);
        end
      end
    end
  end

  // Memory and reference PC update just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (s_rst) begin
      mq.delete();
      exp_q.delete();
      mpc = 32'h0;
    end else begin
      if (s_rsp && mq.size() != 0) void'(mq.pop_front());
      if (s_hs) begin
        mq.push_back('{s_addr, cyc + mem_lat - 1});
        exp_q.push_back('{addr: mpc, inst: word(mpc)});
        mpc = mpc + 32'd4;
      end
      if (s_redir) begin
        exp_q.delete();
        mpc = tmodel(s_tgt);
      end
    end
    imem_rsp_valid = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? word(mq[0].addr) : 32'h0;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(string tag, int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (InstValid) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dropped;
    bit found;
    logic [31:0] wrap_seq [3];

    // Reset and 1-cycle memory streaming
    mem_lat = 1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", FetchBusy, 1);
    check("rst_valid", InstValid, 0);
    check("rst_inst", Inst, NOP);
    check("rst_addr", Addr, 0);
    check("rst_pc", imem_addr, 0);
    check("rst_req", imem_req_valid, 1);
    @(negedge clk);
    check("lat_c1_valid", InstValid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("seq_valid", InstValid, 1);
      check("seq_addr", Addr, 32'(4 * i));
    end

    // Stall with a full buffer
    tick(1);
    StallF = 1'b1;
    tick(8);
    check("full_depth", exp_q.size(), DEPTH);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr", Addr, exp_q[0].addr);
      check("stall_inst", Inst, exp_q[0].inst);
      check("stall_req", imem_req_valid, 0);
      check("stall_rsp", imem_rsp_valid, 0);
    end
    tick(1);
    StallF = 1'b0;
    tick(6);

    // Redirect with two outstanding requests, 4-cycle memory
    rst = 1'b1;
    tick(1);
    mem_lat = 4;
    tick(2);
    rst = 1'b0;
    tick(2);
    imem_req_ready = 1'b0;
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    @(negedge clk);
    check("redir_outst", mq.size(), 2);
    tick(1);
    PCSrcE = 1'b0;
    imem_req_ready = 1'b1;
    dropped = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid) found = 1'b1;
      else begin
        check("drain_busy", FetchBusy, 1);
        if (imem_rsp_valid) dropped++;
      end
    end
    check("drain_end", found, 1);
    check("drain_drops", dropped, 2);
    wait_valid("redir_wait", 20);
    check("redir_addr", Addr, 32'h100);

    // Redirect while stalled with a full buffer
    tick(1);
    StallF = 1'b1;
    tick(12);
    PCSrcE = 1'b1;
    PCTargetE = 32'h300;
    @(negedge clk);
    check("stl_pre_valid", InstValid, 1);
    tick(1);
    PCSrcE = 1'b0;
    @(negedge clk);
    check("stl_flushed", InstValid, 0);
    check("stl_pc", imem_addr, 32'h300);
    check("stl_req", imem_req_valid, 1);
    wait_valid("stl_wait", 20);
    check("stl_addr", Addr, 32'h300);
    tick(1);
    StallF = 1'b0;
    tick(4);

    // Memory not ready
    imem_req_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (FetchBusy && mq.size() == 0) found = 1'b1;
    end
    check("nrdy_empty", found, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nrdy_busy", FetchBusy, 1);
      check("nrdy_valid", InstValid, 0);
      check("nrdy_inst", Inst, NOP);
      check("nrdy_pc", imem_addr, mpc);
    end
    tick(1);
    imem_req_ready = 1'b1;
    tick(10);

    // PC wrap-around
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFF8;
    tick(1);
    PCSrcE = 1'b0;
    wrap_seq[0] = 32'hFFFF_FFF8;
    wrap_seq[1] = 32'hFFFF_FFFC;
    wrap_seq[2] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) wait_valid("wrap_wait", 20);
      else wait_valid("wrap_next", 10);
      check("wrap_addr", Addr, wrap_seq[k]);
      @(posedge clk);
    end
    tick(6);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect target
    PCSrcE = 1'b1;
    PCTargetE = 32'h102;
    @(negedge clk);
    check("mis_pulse", misalign_o, 1);
    tick(1);
    PCSrcE = 1'b0;
    @(negedge clk);
    check("mis_clear", misalign_o, 0);
    wait_valid("mis_wait", 20);
    check("mis_addr", Addr, 32'h100);
    tick(6);
`endif

    // Let everything in flight drain out
    imem_req_ready = 1'b0;
    StallF = 1'b0;
    tick(15);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
